// File: rtl/parking_sensor_gen.sv
// Transmit side of the parking-lot sensor protocol: on request, drives the two
// beam sensor lines through the full blocking sequence of one car entering or
// exiting. Optionally injects LFSR-driven contact bounce on each sensor edge.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous reset, active low
//   start      request one car sequence (accepted only while ready=1)
//   dir        1 = enter, 0 = exit; latched with an accepted start
//   bounce_en  enable bounce injection; latched with an accepted start
//   ready      1 = idle, start is accepted this cycle (registered)
//   done       one-cycle pulse after the sequence completes (registered)
//   a, b       sensor lines, 1 = beam blocked (registered)
module parking_sensor_gen #(
    parameter logic [15:0] PHASE_CYCLES  = 16'd50000,
    parameter logic [15:0] BOUNCE_CYCLES = 16'd0,
    parameter int unsigned CNT_W         = 16,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic dir,
    input  logic bounce_en,
    output logic ready,
    output logic done,
    output logic a,
    output logic b
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 16'd1);
    localparam logic [CNT_W-1:0] BNC_LEN  = CNT_W'(BOUNCE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH1  = 3'd1,
        S_PH2  = 3'd2,
        S_PH3  = 3'd3,
        S_GAP  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic               dir_q, dir_d;
    logic               bnc_q, bnc_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [1:0]         ab_q, ab_d;

    logic               phase_end;
    logic               a_changes;
    logic               bounce_on;
    logic [1:0]         chg_mask;

    // Nominal {a,b} per state for an entering car; exit swaps the two lines.
    function automatic logic [1:0] nominal(input state_e s, input logic d);
        logic [1:0] v;
        case (s)
            S_PH1:   v = 2'b10;
            S_PH2:   v = 2'b11;
            S_PH3:   v = 2'b01;
            default: v = 2'b00;
        endcase
        return d ? v : {v[0], v[1]};
    endfunction

    // Next-state, phase counter, LFSR and registered output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        bnc_d     = bnc_q;
        done_d    = 1'b0;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        phase_end = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PH1;
                    cnt_d   = '0;
                    dir_d   = dir;
                    bnc_d   = bounce_en;
                end
            end
            S_PH1, S_PH2, S_PH3, S_GAP: begin
                if (phase_end) begin
                    cnt_d = '0;
                    case (state_q)
                        S_PH1:   state_d = S_PH2;
                        S_PH2:   state_d = S_PH3;
                        S_PH3:   state_d = S_GAP;
                        default: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Gray sequence: a changes entering PH1/PH3 of an enter (PH2/GAP of an exit).
        a_changes = ((state_d == S_PH1) || (state_d == S_PH3)) == dir_d;
        chg_mask  = a_changes ? 2'b10 : 2'b01;
        bounce_on = bnc_d && (BOUNCE_CYCLES != 16'd0) && (state_d != S_IDLE)
                    && (cnt_d < BNC_LEN);

        // Output tracks the LFSR value held in the same cycle as the output.
        ab_d    = nominal(state_d, dir_d) ^ (bounce_on ? (chg_mask & {2{lfsr_d[0]}}) : 2'b00);
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            dir_q   <= 1'b0;
            bnc_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            ab_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            dir_q   <= dir_d;
            bnc_q   <= bnc_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            ab_q    <= ab_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign a     = ab_q[1];
    assign b     = ab_q[0];

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Scoreboard bench for parking_sensor_gen: a per-cycle reference model turns each
// accepted request into a planned list of sensor states and pushes expectations;
// a negedge monitor pops and compares {a,b,ready,done}.
module tb_parking_sensor_gen;

    localparam logic [15:0] P    = 16'd4;
    localparam logic [15:0] B    = 16'd2;
    localparam logic [7:0]  SEED = 8'hA5;

    logic clk = 1'b0;
    logic reset_n, start, dir, bounce_en;
    logic ready, done, a, b;

    always #5 clk = ~clk;

    parking_sensor_gen #(
        .PHASE_CYCLES (P),
        .BOUNCE_CYCLES(B),
        .CNT_W        (16),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dir      (dir),
        .bounce_en(bounce_en),
        .ready    (ready),
        .done     (done),
        .a        (a),
        .b        (b)
    );

    typedef struct packed {
        logic [1:0] ab;
        logic [1:0] mask;
        logic       rdy;
        logic       dn;
    } ent_t;

    ent_t       plan[$];
    logic [3:0] expq[$];
    logic [7:0] m_lfsr = SEED;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Expand one car into per-cycle entries: 4 phases of P cycles plus the done cycle.
    task automatic build(input logic d, input logic be);
        logic [1:0] seq[4];
        logic [1:0] prev;
        ent_t       e;
        if (d) begin
            seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
        end else begin
            seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        end
        prev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < int'(P); c++) begin
                e.ab   = seq[k];
                e.mask = (be && c < int'(B)) ? (prev ^ seq[k]) : 2'b00;
                e.rdy  = 1'b0;
                e.dn   = 1'b0;
                plan.push_back(e);
            end
            prev = seq[k];
        end
        e.ab = 2'b00; e.mask = 2'b00; e.rdy = 1'b1; e.dn = 1'b1;
        plan.push_back(e);
    endtask

    // Predict the outputs after the coming edge from the current inputs, then clock.
    task automatic step();
        logic [7:0] nl;
        ent_t       e;
        logic [1:0] ab;
        nl = !reset_n ? SEED : lfsr_next(m_lfsr);
        if (!reset_n) begin
            plan.delete();
            expq.push_back(4'b0010);
        end else begin
            if (plan.size() == 0 && start) build(dir, bounce_en);
            if (plan.size() != 0) begin
                e  = plan.pop_front();
                ab = e.ab ^ (e.mask & {2{nl[0]}});
                expq.push_back({ab, e.rdy, e.dn});
            end else begin
                expq.push_back(4'b0010);
            end
        end
        m_lfsr = nl;
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [3:0] ex;
        cyc++;
        if (expq.size() != 0) begin
            ex = expq.pop_front();
            n_tests++;
            if ({a, b, ready, done} !== ex) begin
                n_fail++;
                $display("FAIL outputs cyc%0d {a,b,ready,done} got %b%b%b%b exp %b", cyc, a, b,
                         ready, done, ex);
            end
        end
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; dir = 1'b0; bounce_en = 1'b0;
        step(); step();
        reset_n = 1'b1;
        step();

        // Enter with ignored starts at cyc3/cyc10, start held in the done cycle.
        start = 1'b1; dir = 1'b1;
        step();
        for (int i = 1; i <= 17; i++) begin
            start = (i == 3 || i == 10 || i == 17);
            dir   = (i % 2 == 0);
            step();
        end
        start = 1'b0;
        for (int i = 0; i < 17; i++) step();

        // Exit.
        start = 1'b1; dir = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 19; i++) step();

        // Reset mid-sequence at cyc6.
        start = 1'b1; dir = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            reset_n = (i != 6);
            step();
        end
        reset_n = 1'b1;

        // Bounce on enter and exit, with mid-sequence toggling of latched inputs.
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; dir = (k == 0); bounce_en = 1'b1;
            step();
            start = 1'b0;
            for (int i = 0; i < 18; i++) begin
                bounce_en = i[0];
                dir       = i[1];
                step();
            end
        end

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            dir       = $urandom_range(0, 1) != 0;
            bounce_en = $urandom_range(0, 1) != 0;
            reset_n   = ($urandom_range(0, 199) != 0);
            step();
        end
        reset_n = 1'b1; start = 1'b0;
        step(); step();
        @(posedge clk);
        #1;
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending got %0d exp 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
